mem_load_unit: RTL and testbench
================================

# mem_load_unit

Load-side memory access unit for the data path: accepts a load request (address, `mem_mode` width, signedness) from the execute stage, issues a word-aligned read on the data-memory bus, and returns the selected byte/halfword/word, zero- or sign-extended to `cpu_word`. It is the read counterpart of the store-side byte merge. Sits between the CPU load/store stage and the data-memory port, with valid/ready handshakes on both sides and a status code for misalignment, bus error and timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: max cycles spent waiting for read data after grant before aborting (≥1).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqValid` in 1: load request valid.
- `reqReady` out 1: unit can accept a request.
- `reqAddr` in `cpu_word`: byte address.
- `reqMode` in `mem_mode`: `MEM_W`/`MEM_H`/`MEM_B`.
- `reqUnsigned` in 1: 1 = zero-extend, 0 = sign-extend (ignored for `MEM_W`).
- `respValid` out 1: result valid.
- `respReady` in 1: consumer takes result.
- `respData` out `cpu_word`: extended load data.
- `respStatus` out `load_status`: `LOAD_OK`, `LOAD_MISALIGNED`, `LOAD_BUS_ERR`, `LOAD_TIMEOUT`.
- `memReq` out 1: read request to memory.
- `memAddr` out `cpu_word`: word address, bits [1:0] always 0.
- `memGnt` in 1: memory accepted request.
- `memRvalid` in 1: read data valid.
- `memRdata` in `cpu_word`: read data.
- `memErr` in 1: bus error, qualified by `memRvalid`.

## Operation
- FSM states: `IDLE`, `ADDR`, `DATA`, `RESP`. `reqReady` = (state == `IDLE`); one transaction in flight.
- `IDLE`: on `reqValid && reqReady`, latch addr/mode/unsigned. If misaligned (`MEM_W` with addr[1:0] ≠ 0, `MEM_H` with addr[0] = 1): go to `RESP` with `respData` = 0 and `LOAD_MISALIGNED`; no memory access. Otherwise go to `ADDR`.
- `ADDR`: `memReq` = 1, `memAddr` = {addr[31:2], 2'b00}, held stable until `memGnt`; on `memGnt` go to `DATA` and clear the timeout counter. `memRvalid` is ignored in `ADDR`.
- `DATA`: on `memRvalid`, register the extracted word and status (`LOAD_BUS_ERR` with `respData` = 0 if `memErr`, else `LOAD_OK`), then go to `RESP`. Otherwise increment the counter; when it reaches `TIMEOUT_CYCLES`, go to `RESP` with `LOAD_TIMEOUT`, `respData` = 0.
- `RESP`: `respValid` = 1, data and status stable; on `respReady` go to `IDLE`.
- Extraction: `MEM_W` passes the word through. `MEM_H` uses addr[1] to select [31:16], else [15:0]. `MEM_B` uses addr[1:0] to select byte 0..3 (byte 0 = [7:0]). Sign-extend from bit 15 or bit 7 unless `reqUnsigned`.
- `memRvalid` in `IDLE`/`ADDR`/`RESP` is ignored (late data after timeout is discarded). The bus guarantees at most one outstanding read.

## Timing
- Reset (async, immediate): state `IDLE`, `reqReady` = 1, `respValid` = 0, `respData` = 0, `respStatus` = `LOAD_OK`, `memReq` = 0, `memAddr` = 0, counter = 0. Reset mid-transaction abandons it; `memReq` drops combinationally with reset.
- Zero-wait path: accept at edge 0, `memReq` high in cycle 1 with `memGnt`, `memRvalid` in cycle 2, `respValid` in cycle 3. Minimum 4 cycles per load.
- Misaligned path: `respValid` in the cycle after acceptance.
- All outputs are registered or decoded from state only; there is no combinational path from `req*`/`mem*` inputs to outputs.

## Structure
- Add `load_status` enum to package `base` next to `mem_mode` and `cpu_word`. Add the FSM state enum locally.
- One combinational sub-module `mem_load_extract` (inputs: word, `mem_mode`, byteAdr[1:0], unsigned; output: extended `cpu_word`), verified standalone. Misalignment check lives in the top-level unit.

## Test plan
- LB signed, addr 0x1003, `memRdata` 0x80123456, zero-wait → `memAddr` 0x1000, `respData` 0xFFFFFF80, `LOAD_OK`, `respValid` in cycle 3.
- LHU addr 0x2002, `memRdata` 0xBEEF1234 → 0x0000BEEF; LH same → 0xFFFFBEEF; LH addr 0x2000 → 0x00001234.
- LW addr 0x1002 → no `memReq` ever, `respValid` in cycle 1, `LOAD_MISALIGNED`, `respData` 0.
- `memGnt` delayed 3 cycles, `respReady` low for 2 cycles → `memAddr` stable until grant, `respData` stable until handshake, `reqReady` low throughout.
- `TIMEOUT_CYCLES` = 4, no `memRvalid` → `LOAD_TIMEOUT` after 4 `DATA` cycles; a late `memRvalid` in `IDLE` does not affect the next load. `memErr` with `memRvalid` → `LOAD_BUS_ERR`, `respData` 0.
- `rst_n` pulsed low in `DATA` → all outputs at reset values immediately; the following LW at 0x0 returns `memRdata` correctly.

Source files
------------

// File: rtl/base.sv
// Shared data-path types: CPU word, memory access width and load completion status.
package base;

    localparam int CPU_WORD_W = 32;

    typedef logic [CPU_WORD_W-1:0] cpu_word;

    // Access width of a load or store.
    typedef enum logic [1:0] {
        MEM_W = 2'd0,
        MEM_H = 2'd1,
        MEM_B = 2'd2
    } mem_mode;

    // Completion code returned with every load result.
    typedef enum logic [1:0] {
        LOAD_OK         = 2'd0,
        LOAD_MISALIGNED = 2'd1,
        LOAD_BUS_ERR    = 2'd2,
        LOAD_TIMEOUT    = 2'd3
    } load_status;

endpackage

// File: rtl/mem_load_extract.sv
// Selects a byte/halfword/word from a bus word and zero- or sign-extends it.
module mem_load_extract
    import base::*;
(
    input  cpu_word    word,
    input  mem_mode    mode,
    input  logic [1:0] byteAdr,
    input  logic       isUnsigned,
    output cpu_word    data
);

    logic [15:0] half;
    logic [7:0]  byteSel;

    // Lane selection: addr[1] picks the halfword, addr[1:0] picks the byte.
    always_comb begin
        half    = byteAdr[1] ? word[31:16] : word[15:0];
        byteSel = word[7:0];
        case (byteAdr)
            2'd0:    byteSel = word[7:0];
            2'd1:    byteSel = word[15:8];
            2'd2:    byteSel = word[23:16];
            default: byteSel = word[31:24];
        endcase
    end

    // Extension to a full word; an unknown mode encoding behaves like a word load.
    always_comb begin
        data = word;
        case (mode)
            MEM_H:   data = {{16{half[15] & ~isUnsigned}}, half};
            MEM_B:   data = {{24{byteSel[7] & ~isUnsigned}}, byteSel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: accepts one load, issues a word-aligned memory read and returns
// the extended result with a status code. One transaction in flight at a time.
module mem_load_unit
    import base::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       reqValid,
    output logic       reqReady,
    input  cpu_word    reqAddr,
    input  mem_mode    reqMode,
    input  logic       reqUnsigned,
    output logic       respValid,
    input  logic       respReady,
    output cpu_word    respData,
    output load_status respStatus,
    output logic       memReq,
    output cpu_word    memAddr,
    input  logic       memGnt,
    input  logic       memRvalid,
    input  cpu_word    memRdata,
    input  logic       memErr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state;
    state_t           stateNext;
    cpu_word          addrReg;
    mem_mode          modeReg;
    logic             unsignedReg;
    logic [CNT_W-1:0] cnt;
    cpu_word          extData;
    logic             misaligned;
    logic             accept;
    logic             loadResp;
    logic             cntClear;
    logic             cntInc;
    cpu_word          respDataNext;
    load_status       respStatusNext;

    mem_load_extract u_extract (
        .word       (memRdata),
        .mode       (modeReg),
        .byteAdr    (addrReg[1:0]),
        .isUnsigned (unsignedReg),
        .data       (extData)
    );

    assign misaligned = ((reqMode == MEM_W) && (reqAddr[1:0] != 2'b00)) ||
                        ((reqMode == MEM_H) && reqAddr[0]);

    // Word-aligned bus address comes straight from the latched request.
    assign memAddr = {addrReg[CPU_WORD_W-1:2], 2'b00};

    // State register; reset abandons any transaction and drops memReq at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode, datapath strobes and state-decoded handshake outputs.
    always_comb begin
        stateNext      = state;
        accept         = 1'b0;
        loadResp       = 1'b0;
        cntClear       = 1'b0;
        cntInc         = 1'b0;
        respDataNext   = '0;
        respStatusNext = LOAD_OK;
        reqReady       = (state == IDLE);
        memReq         = (state == ADDR);
        respValid      = (state == RESP);
        case (state)
            IDLE: begin
                if (reqValid) begin
                    accept = 1'b1;
                    if (misaligned) begin
                        loadResp       = 1'b1;
                        respStatusNext = LOAD_MISALIGNED;
                        stateNext      = RESP;
                    end else begin
                        stateNext = ADDR;
                    end
                end
            end
            ADDR: begin
                if (memGnt) begin
                    cntClear  = 1'b1;
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (memRvalid) begin
                    loadResp  = 1'b1;
                    stateNext = RESP;
                    if (memErr) begin
                        respStatusNext = LOAD_BUS_ERR;
                    end else begin
                        respDataNext = extData;
                    end
                end else if (cnt == CNT_LAST) begin
                    loadResp       = 1'b1;
                    respStatusNext = LOAD_TIMEOUT;
                    stateNext      = RESP;
                end else begin
                    cntInc = 1'b1;
                end
            end
            RESP: begin
                if (respReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Request latch, wait counter and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrReg     <= '0;
            modeReg     <= MEM_W;
            unsignedReg <= 1'b0;
            cnt         <= '0;
            respData    <= '0;
            respStatus  <= LOAD_OK;
        end else begin
            if (accept) begin
                addrReg     <= reqAddr;
                modeReg     <= reqMode;
                unsignedReg <= reqUnsigned;
            end
            if (cntClear) begin
                cnt <= '0;
            end else if (cntInc) begin
                cnt <= cnt + 1'b1;
            end
            if (loadResp) begin
                respData   <= respDataNext;
                respStatus <= respStatusNext;
            end
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Lockstep bench for mem_load_unit: directed cases plus randomized loads
// checked against a behavioural extraction model.
module tb_mem_load_unit;
    import base::*;

    localparam int TO = 4;

    logic       clk;
    logic       rst_n;
    logic       reqValid;
    logic       reqReady;
    cpu_word    reqAddr;
    mem_mode    reqMode;
    logic       reqUnsigned;
    logic       respValid;
    logic       respReady;
    cpu_word    respData;
    load_status respStatus;
    logic       memReq;
    cpu_word    memAddr;
    logic       memGnt;
    logic       memRvalid;
    cpu_word    memRdata;
    logic       memErr;

    cpu_word    xWord;
    mem_mode    xMode;
    logic [1:0] xAdr;
    logic       xUns;
    cpu_word    xData;

    int checks = 0;
    int fails  = 0;

    mem_load_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqAddr     (reqAddr),
        .reqMode     (reqMode),
        .reqUnsigned (reqUnsigned),
        .respValid   (respValid),
        .respReady   (respReady),
        .respData    (respData),
        .respStatus  (respStatus),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memGnt      (memGnt),
        .memRvalid   (memRvalid),
        .memRdata    (memRdata),
        .memErr      (memErr)
    );

    mem_load_extract u_x (
        .word       (xWord),
        .mode       (xMode),
        .byteAdr    (xAdr),
        .isUnsigned (xUns),
        .data       (xData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference: shift the addressed lane down, mask to width, extend by arithmetic.
    function automatic logic [31:0] refExtract(input logic [31:0] w, input mem_mode m,
                                               input logic [1:0] a, input logic u);
        int unsigned bits;
        int unsigned sh;
        logic [31:0] mask;
        logic [31:0] v;
        if (m == MEM_W) return w;
        bits = (m == MEM_H) ? 16 : 8;
        sh   = (m == MEM_H) ? (a >= 2 ? 16 : 0) : 8 * a;
        mask = (32'h1 << bits) - 32'h1;
        v    = (w >> sh) & mask;
        if (!u && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic bit isMisaligned(input logic [31:0] a, input mem_mode m);
        if (m == MEM_W) return (a % 4) != 0;
        if (m == MEM_H) return (a % 2) != 0;
        return 1'b0;
    endfunction

    // One complete load in lockstep, driven and sampled on falling edges.
    // dropData = 1 withholds read data so the unit must time out.
    task automatic applyStimulus(input logic [31:0] addr, input mem_mode mode, input logic uns,
                                 input logic [31:0] rdata, input logic err,
                                 input int gntDelay, input int dataDelay, input int respDelay,
                                 input bit dropData, output int latency);
        bit          mis;
        logic [31:0] expData;
        logic [31:0] expAddr;
        load_status  expStatus;
        mis     = isMisaligned(addr, mode);
        expAddr = addr - (addr % 4);
        if (mis) begin
            expData = 0; expStatus = LOAD_MISALIGNED;
        end else if (dropData) begin
            expData = 0; expStatus = LOAD_TIMEOUT;
        end else if (err) begin
            expData = 0; expStatus = LOAD_BUS_ERR;
        end else begin
            expData = refExtract(rdata, mode, addr[1:0], uns); expStatus = LOAD_OK;
        end
        latency = 0;
        checkOutput("reqReadyIdle", {31'b0, reqReady}, 32'd1);
        reqValid = 1'b1; reqAddr = addr; reqMode = mode; reqUnsigned = uns;
        @(negedge clk); latency++;
        reqValid = 1'b0; reqAddr = $urandom; reqMode = mem_mode'($urandom_range(0, 2));
        if (!mis) begin
            for (int i = 0; i < gntDelay; i++) begin
                checkOutput("memReqWait", {31'b0, memReq}, 32'd1);
                checkOutput("memAddrWait", memAddr, expAddr);
                checkOutput("reqReadyBusy", {31'b0, reqReady}, 32'd0);
                memRvalid = 1'b1; memRdata = $urandom; memErr = $urandom_range(0, 1);
                @(negedge clk); latency++;
            end
            memRvalid = 1'b0; memErr = 1'b0;
            checkOutput("memReq", {31'b0, memReq}, 32'd1);
            checkOutput("memAddr", memAddr, expAddr);
            memGnt = 1'b1;
            @(negedge clk); latency++;
            memGnt = 1'b0;
            if (dropData) begin
                for (int i = 0; i < TO; i++) begin
                    checkOutput("respValidWaitTO", {31'b0, respValid}, 32'd0);
                    checkOutput("memReqData", {31'b0, memReq}, 32'd0);
                    @(negedge clk); latency++;
                end
            end else begin
                for (int i = 0; i < dataDelay; i++) begin
                    checkOutput("respValidWaitData", {31'b0, respValid}, 32'd0);
                    @(negedge clk); latency++;
                end
                memRvalid = 1'b1; memRdata = rdata; memErr = err;
                @(negedge clk); latency++;
                memRvalid = 1'b0; memErr = 1'b0; memRdata = $urandom;
            end
        end
        for (int i = 0; i < respDelay; i++) begin
            checkOutput("respValidHold", {31'b0, respValid}, 32'd1);
            checkOutput("respDataHold", respData, expData);
            checkOutput("reqReadyResp", {31'b0, reqReady}, 32'd0);
            @(negedge clk);
        end
        checkOutput("respValid", {31'b0, respValid}, 32'd1);
        checkOutput("respData", respData, expData);
        checkOutput("respStatus", {30'b0, respStatus}, {30'b0, expStatus});
        checkOutput("memReqResp", {31'b0, memReq}, 32'd0);
        respReady = 1'b1;
        @(negedge clk);
        respReady = 1'b0;
        checkOutput("respValidDone", {31'b0, respValid}, 32'd0);
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; reqValid = 1'b0; reqAddr = '0; reqMode = MEM_W; reqUnsigned = 1'b0;
        respReady = 1'b0; memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0; memErr = 1'b0;
        xWord = '0; xMode = MEM_W; xAdr = '0; xUns = 1'b0;
        #12;
        checkOutput("rstReqReady", {31'b0, reqReady}, 32'd1);
        checkOutput("rstRespValid", {31'b0, respValid}, 32'd0);
        checkOutput("rstRespData", respData, 32'd0);
        checkOutput("rstRespStatus", {30'b0, respStatus}, {30'b0, LOAD_OK});
        checkOutput("rstMemReq", {31'b0, memReq}, 32'd0);
        checkOutput("rstMemAddr", memAddr, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'h1003, MEM_B, 1'b0, 32'h80123456, 1'b0, 0, 0, 0, 1'b0, lat);
        checkOutput("zeroWaitLatency", lat, 32'd3);
        checkOutput("lbDirect", refExtract(32'h80123456, MEM_B, 2'd3, 1'b0), 32'hFFFFFF80);
        applyStimulus(32'h2002, MEM_H, 1'b1, 32'hBEEF1234, 1'b0, 0, 0, 0, 1'b0, lat);
        applyStimulus(32'h2002, MEM_H, 1'b0, 32'hBEEF1234, 1'b0, 0, 0, 0, 1'b0, lat);
        applyStimulus(32'h2000, MEM_H, 1'b0, 32'hBEEF1234, 1'b0, 0, 0, 0, 1'b0, lat);
        applyStimulus(32'h1002, MEM_W, 1'b0, 32'h12345678, 1'b0, 0, 0, 0, 1'b0, lat);
        checkOutput("misalignLatency", lat, 32'd1);
        applyStimulus(32'h3005, MEM_H, 1'b1, 32'h12345678, 1'b0, 0, 0, 1, 1'b0, lat);
        applyStimulus(32'h4001, MEM_B, 1'b1, 32'hCAFEF00D, 1'b0, 3, 1, 2, 1'b0, lat);
        applyStimulus(32'h5008, MEM_W, 1'b0, 32'hDEADBEEF, 1'b0, 0, 0, 0, 1'b1, lat);
        checkOutput("timeoutLatency", lat, 32'd3 + TO - 1);

        // Late read data arriving while idle must not disturb the next load.
        memRvalid = 1'b1; memRdata = 32'hFFFFFFFF; memErr = 1'b1;
        @(negedge clk);
        memRvalid = 1'b0; memErr = 1'b0;
        applyStimulus(32'h6000, MEM_B, 1'b0, 32'h00000071, 1'b0, 0, 0, 0, 1'b0, lat);
        applyStimulus(32'h7004, MEM_W, 1'b0, 32'h55555555, 1'b1, 1, 1, 0, 1'b0, lat);

        // Reset pulsed while waiting for read data.
        reqValid = 1'b1; reqAddr = 32'h8004; reqMode = MEM_W;
        @(negedge clk);
        reqValid = 1'b0; memGnt = 1'b1;
        @(negedge clk);
        memGnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstMemReq", {31'b0, memReq}, 32'd0);
        checkOutput("midRstReqReady", {31'b0, reqReady}, 32'd1);
        checkOutput("midRstRespValid", {31'b0, respValid}, 32'd0);
        checkOutput("midRstMemAddr", memAddr, 32'd0);
        checkOutput("midRstRespData", respData, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'h0, MEM_W, 1'b0, 32'hA5A55A5A, 1'b0, 0, 0, 0, 1'b0, lat);

        // Randomized loads.
        for (int n = 0; n < 40; n++) begin
            applyStimulus($urandom, mem_mode'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                          $urandom, ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 3), $urandom_range(0, TO - 2), $urandom_range(0, 2),
                          ($urandom_range(0, 9) == 0), lat);
        end

        // Extractor on its own.
        for (int n = 0; n < 30; n++) begin
            xWord = $urandom; xMode = mem_mode'($urandom_range(0, 2));
            xAdr = 2'($urandom_range(0, 3)); xUns = 1'($urandom_range(0, 1));
            #1;
            checkOutput("extract", xData, refExtract(xWord, xMode, xAdr, xUns));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
